// File: rtl/kernel_offset_buf_if.sv
// kernel_offset_buf_if: stream face of the offset stage.
// Carries the upstream valid/ready word and the downstream registered
// pair (current element + lagged element) with its valid/ready.
// master = side that drives the input word and consumes the pair
// slave  = the offset buffer itself
interface kernel_offset_buf_if #(
  parameter int STREAMW = 34
) ();

  // Upstream word towards the buffer
  logic               ivalid_in1_s0;
  logic [STREAMW-1:0] in1_s0;
  logic               iready;

  // Registered output pair towards the leaf map node
  logic               ovalid;
  logic [STREAMW-1:0] out1_s0;
  logic [STREAMW-1:0] out1_off_s0;
  logic               oready;

  modport master (
    output ivalid_in1_s0,
    output in1_s0,
    input  iready,
    input  ovalid,
    input  out1_s0,
    input  out1_off_s0,
    output oready
  );

  modport slave (
    input  ivalid_in1_s0,
    input  in1_s0,
    output iready,
    output ovalid,
    output out1_s0,
    output out1_off_s0,
    input  oready
  );

endinterface

// File: rtl/kernel_offset_buf.sv
// kernel_offset_buf: per accepted element emits x[i] together with
// x[i-OFFSET] from the same frame, through one registered output stage
// with backpressure. The lagged value comes from an OFFSET-deep circular
// history RAM. While fewer than OFFSET elements of the current frame have
// arrived (FILL), the lagged value comes from a fill source instead of RAM.
//
// Build option: define OFFSET_ZERO_FILL_EN to emit 0 as the lagged value
// during FILL. Without it, FILL emits the frame's first element
// (edge-clamp), and the first-element register exists only in that build.
module kernel_offset_buf #(
  parameter int STREAMW = 34,
  parameter int OFFSET  = 4,
  parameter int NITEMS  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  kernel_offset_buf_if.slave bus
);

  // Counter widths: idx covers 0..NITEMS-1, wp covers 0..OFFSET-1.
  localparam int IDXW = (NITEMS > 1) ? $clog2(NITEMS) : 1;
  localparam int WPW  = (OFFSET > 1) ? $clog2(OFFSET) : 1;

  localparam logic [IDXW-1:0] IDX_LAST_ITEM = IDXW'(NITEMS - 1);
  localparam logic [IDXW-1:0] IDX_LAST_FILL = IDXW'(OFFSET - 1);
  localparam logic [WPW-1:0]  WP_LAST       = WPW'(OFFSET - 1);

  // Reject configurations the frame/history logic cannot represent.
  if (OFFSET < 1) begin : g_bad_offset
    $error("kernel_offset_buf: OFFSET must be at least 1");
  end
  if (NITEMS <= OFFSET) begin : g_bad_nitems
    $error("kernel_offset_buf: NITEMS must be greater than OFFSET");
  end

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [WPW-1:0]     wp_q, wp_d;

  logic               ovalid_q, ovalid_d;
  logic [STREAMW-1:0] out_cur_q, out_cur_d;
  logic [STREAMW-1:0] out_off_q, out_off_d;

  // History RAM; contents are never reset because FILL never exposes them.
  logic [STREAMW-1:0] hist_mem [OFFSET];

  // ------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------
  logic iready;
  logic acc;
  logic frame_last;
  logic fill_last;

  assign iready     = bus.oready | ~ovalid_q;
  assign acc        = bus.ivalid_in1_s0 & iready;
  assign frame_last = (idx_q == IDX_LAST_ITEM);
  assign fill_last  = (idx_q == IDX_LAST_FILL);

  // ------------------------------------------------------------------
  // Fill source
  // ------------------------------------------------------------------
  logic [STREAMW-1:0] fill_val;

`ifdef OFFSET_ZERO_FILL_EN
  // Zero-fill: nothing to remember about the frame.
  always_comb begin
    fill_val = '0;
  end
`else
  // Edge-clamp: remember the frame's first element. The idx-0 element
  // clamps to itself, since it is not yet in the register.
  logic [STREAMW-1:0] first_q, first_d;

  // First-element register next state: load on the idx-0 accept. A frame
  // wrap returns idx to 0, which re-arms this load for the next frame.
  always_comb begin
    first_d = first_q;
    if (acc && (idx_q == '0)) begin
      first_d = bus.in1_s0;
    end
  end

  // First-element register.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= '0;
    end else begin
      first_q <= first_d;
    end
  end

  // Fill value selection for edge-clamp.
  always_comb begin
    fill_val = (idx_q == '0) ? bus.in1_s0 : first_q;
  end
`endif

  // ------------------------------------------------------------------
  // FSM: FILL until OFFSET elements of the frame are in, then RUN until
  // the last element of the frame.
  // ------------------------------------------------------------------

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; transitions only happen on an accepted element.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (acc && fill_last)  state_d = ST_RUN;
      ST_RUN:  if (acc && frame_last) state_d = ST_FILL;
      default: state_d = ST_FILL;
    endcase
  end

  // FSM output logic: choose where the lagged element comes from. In RUN
  // the slot at wp holds the oldest element, x[i-OFFSET]; it is read here
  // before this cycle's write replaces it.
  logic [STREAMW-1:0] lagged;
  always_comb begin
    lagged = fill_val;
    if (state_q == ST_RUN) begin
      lagged = hist_mem[wp_q];
    end
  end

  // ------------------------------------------------------------------
  // Counters
  // ------------------------------------------------------------------

  // Item counter and write pointer next state; both restart at frame wrap
  // so every frame's history starts from slot 0.
  always_comb begin
    idx_d = idx_q;
    wp_d  = wp_q;
    if (acc) begin
      if (frame_last) begin
        idx_d = '0;
        wp_d  = '0;
      end else begin
        idx_d = idx_q + IDXW'(1);
        wp_d  = (wp_q == WP_LAST) ? '0 : wp_q + WPW'(1);
      end
    end
  end

  // Item counter and write pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      wp_q  <= '0;
    end else begin
      idx_q <= idx_d;
      wp_q  <= wp_d;
    end
  end

  // History write: the accepted element overwrites the slot just read.
  always_ff @(posedge clk) begin
    if (acc) begin
      hist_mem[wp_q] <= bus.in1_s0;
    end
  end

  // ------------------------------------------------------------------
  // Output stage
  // ------------------------------------------------------------------

  // Output register next state: load on accept (also when draining the
  // old pair in the same cycle), empty on drain, otherwise hold.
  always_comb begin
    ovalid_d  = ovalid_q;
    out_cur_d = out_cur_q;
    out_off_d = out_off_q;
    if (acc) begin
      ovalid_d  = 1'b1;
      out_cur_d = bus.in1_s0;
      out_off_d = lagged;
    end else if (bus.oready) begin
      ovalid_d  = 1'b0;
    end
  end

  // Output register; reset drops any pair in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovalid_q  <= 1'b0;
      out_cur_q <= '0;
      out_off_q <= '0;
    end else begin
      ovalid_q  <= ovalid_d;
      out_cur_q <= out_cur_d;
      out_off_q <= out_off_d;
    end
  end

  assign bus.iready      = iready;
  assign bus.ovalid      = ovalid_q;
  assign bus.out1_s0     = out_cur_q;
  assign bus.out1_off_s0 = out_off_q;

endmodule

// File: tb/tb_kernel_offset_buf.sv
// Testbench for kernel_offset_buf: directed test-plan sequences plus a
// randomized stream with random gaps and random backpressure. Expected
// pairs come from a frame-history model and are checked by a monitor.
module tb_kernel_offset_buf;

  localparam int W   = 34;
  localparam int OFF = 4;
  localparam int NI  = 12;

  typedef struct packed {
    logic [W-1:0] cur;
    logic [W-1:0] off;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kernel_offset_buf_if #(.STREAMW(W)) bus ();

  kernel_offset_buf #(
    .STREAMW(W),
    .OFFSET (OFF),
    .NITEMS (NI)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  pair_t        exp_q[$];
  logic [W-1:0] frame[$];
  int           fcnt = 0;
  bit           bp_random = 1'b0;
  bit           log_en = 1'b0;
  logic [W-1:0] log_off[$];

  function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: element i of a frame lags to element i-OFFSET of the
  // same frame; before that, to the fill value.
  function automatic void model_reset();
    frame.delete();
    fcnt = 0;
  endfunction

  function automatic pair_t model_accept(logic [W-1:0] v);
    pair_t p;
    if (fcnt == 0) frame.delete();
    frame.push_back(v);
    p.cur = v;
    if (fcnt >= OFF) begin
      p.off = frame[fcnt-OFF];
    end else begin
`ifdef OFFSET_ZERO_FILL_EN
      p.off = '0;
`else
      p.off = frame[0];
`endif
    end
    fcnt = (fcnt == NI-1) ? 0 : fcnt + 1;
    return p;
  endfunction

  // Random backpressure, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (bp_random) bus.oready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops and compares on every transfer, checks stalls hold.
  logic [W-1:0] hold_cur, hold_off;
  bit           hold_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (bus.ovalid) check("ovalid_has_pending", W'(exp_q.size() != 0), W'(1));
      if (bus.ovalid && !bus.oready) begin
        if (hold_v) begin
          check("stall_hold_cur", bus.out1_s0, hold_cur);
          check("stall_hold_off", bus.out1_off_s0, hold_off);
        end
        check("stall_iready", W'(bus.iready), W'(0));
        hold_cur = bus.out1_s0;
        hold_off = bus.out1_off_s0;
        hold_v   = 1'b1;
      end else begin
        hold_v = 1'b0;
      end
      if (bus.ovalid && bus.oready && exp_q.size() != 0) begin
        pair_t e;
        e = exp_q.pop_front();
        $display("[TB] out cur=%0d off=%0d exp_cur=%0d exp_off=%0d",
                 bus.out1_s0, bus.out1_off_s0, e.cur, e.off);
        check("out_cur", bus.out1_s0, e.cur);
        check("out_off", bus.out1_off_s0, e.off);
        if (log_en) log_off.push_back(bus.out1_off_s0);
      end
    end
  end

  // Offer one word after 'gap' idle cycles; returns just after the accept edge.
  task automatic send(input logic [W-1:0] v, input int gap);
    int  n;
    bit  ok;
    bus.ivalid_in1_s0 = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.ivalid_in1_s0 = 1'b1;
    bus.in1_s0        = v;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.iready) begin
        ok = 1'b1;
      end else begin
        n++;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: word %0d not accepted in 200 cycles", v);
      bus.ivalid_in1_s0 = 1'b0;
    end else begin
      exp_q.push_back(model_accept(v));
      @(posedge clk);
      #1;
      bus.ivalid_in1_s0 = 1'b0;
      check("latency_ovalid", W'(bus.ovalid), W'(1));
      check("latency_cur", bus.out1_s0, v);
    end
  endtask

  task automatic drain();
    int n;
    bp_random  = 1'b0;
    bus.oready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", W'(exp_q.size()), W'(0));
  endtask

  task automatic check_log(string name, input logic [W-1:0] expv[$]);
    check({name, "_count"}, W'(log_off.size()), W'(expv.size()));
    foreach (expv[i]) begin
      if (i < log_off.size()) check(name, log_off[i], expv[i]);
    end
  endtask

  initial begin
    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];
    bus.ivalid_in1_s0 = 1'b0;
    bus.in1_s0        = '0;
    bus.oready        = 1'b1;
    model_reset();

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_ovalid", W'(bus.ovalid), W'(0));
    check("reset_out", bus.out1_s0, W'(0));
    check("reset_off", bus.out1_off_s0, W'(0));
    check("reset_iready", W'(bus.iready), W'(1));
    @(posedge clk);
    #1;

    // Stream 1..8 with a 3-cycle stall after element 5
    log_off.delete();
    log_en = 1'b1;
    for (int v = 1; v <= 5; v++) send(W'(v), 0);
    bus.oready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_ovalid", W'(bus.ovalid), W'(1));
      check("bp_iready", W'(bus.iready), W'(0));
      check("bp_cur", bus.out1_s0, W'(5));
      check("bp_off", bus.out1_off_s0, W'(1));
    end
    @(posedge clk);
    #1;
    bus.oready = 1'b1;
    for (int v = 6; v <= 8; v++) send(W'(v), 0);
    repeat (2) @(posedge clk);
    #1;
    log_en = 1'b0;
`ifdef OFFSET_ZERO_FILL_EN
    exp_a = '{W'(0), W'(0), W'(0), W'(0), W'(1), W'(2), W'(3), W'(4)};
`else
    exp_a = '{W'(1), W'(1), W'(1), W'(1), W'(1), W'(2), W'(3), W'(4)};
`endif
    check_log("seq1_off", exp_a);

    // Randomized stream with gaps and backpressure, across frame wraps
    bp_random = 1'b1;
    for (int k = 0; k < 70; k++) begin
      send({$urandom, $urandom}, int'($urandom_range(0, 2)));
    end
    drain();

    // Mid-frame reset, then restart 7,8,9
    send(W'(100), 0);
    send(W'(101), 0);
    send(W'(102), 0);
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ovalid", W'(bus.ovalid), W'(0));
    check("rst_mid_iready", W'(bus.iready), W'(1));
    @(posedge clk);
    #1;
    log_off.delete();
    log_en = 1'b1;
    send(W'(7), 1);
    send(W'(8), 1);
    send(W'(9), 1);
    repeat (2) @(posedge clk);
    #1;
    log_en = 1'b0;
`ifdef OFFSET_ZERO_FILL_EN
    exp_b = '{W'(0), W'(0), W'(0)};
`else
    exp_b = '{W'(7), W'(7), W'(7)};
`endif
    check_log("rst_restart_off", exp_b);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/kernel_offset_buf.md
# kernel_offset_buf

Upstream stream-offset stage for the TyTra kernel pipeline. Accepts one scalar stream and emits, per accepted element, the current element and the element OFFSET positions earlier in the same frame. The lagged value comes from a circular history buffer. It drives the valid/ready input face of a leaf map node (`ivalid_in1_s0`/`in1_s0`/`iready`) and presents a single registered output stage with backpressure.

## Interface
- `STREAMW`, 34: data width of every stream word.
- `OFFSET`, 4: lag in elements, ≥1; history depth.
- `NITEMS`, 1024: elements per frame, must be greater than OFFSET; history is cleared at each frame boundary.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ivalid_in1_s0`  in  1  upstream word valid.
- `in1_s0`  in  STREAMW  upstream word.
- `iready`  out  1  this block can accept a word this cycle.
- `ovalid`  out  1  output pair valid.
- `out1_s0`  out  STREAMW  current element x[i], registered.
- `out1_off_s0`  out  STREAMW  lagged element x[i-OFFSET], registered.
- `oready`  in  1  downstream accepts the pair this cycle.

## Operation
- Accept condition: `acc = ivalid_in1_s0 & iready`.
- `iready = oready | ~ovalid`. This is a single pipeline register; there is no skid entry.
- History RAM: OFFSET entries. Write pointer `wp` runs 0..OFFSET-1 and wraps to 0.
- On `acc`:
  - read `mem[wp]`, which is the oldest entry, x[i-OFFSET];
  - write `in1_s0` to `mem[wp]`;
  - advance `wp`.
- Item counter `idx` runs 0..NITEMS-1. It increments on `acc` and wraps to 0 after NITEMS-1.
- FSM state FILL:
  - entered at reset and after each frame wrap;
  - active while `idx < OFFSET`;
  - the lagged output comes from the fill source (see Configuration), not from RAM.
- FSM state RUN:
  - `idx ≥ OFFSET`;
  - lagged output = RAM read data.
- Transitions:
  - FILL→RUN on `acc` with `idx == OFFSET-1`;
  - RUN→FILL on `acc` with `idx == NITEMS-1`. At the same time `wp` and `idx` reset to 0, and the first-element register is re-armed.
- First-element register `first`: loaded on `acc` when `idx == 0`.
- Output register: on `acc`, `out1_s0 <= in1_s0`, `out1_off_s0 <= lagged`, and `ovalid <= 1`.
- If there is no `acc` and `oready` is high, `ovalid <= 0`. Otherwise the output register holds.
- Arithmetic: none on data; values pass through at full STREAMW width.
  - `idx` is ceil(log2(NITEMS)) bits.
  - `wp` is max(1, ceil(log2(OFFSET))) bits.

## Timing
- Reset values:
  - `ovalid=0`, `out1_s0=0`, `out1_off_s0=0`;
  - `iready=1`, since `ovalid=0`;
  - `wp=0`, `idx=0`, state FILL, `first=0`.
- RAM contents are not reset. They are never exposed in FILL.
- Latency: 1 cycle, accept edge to `ovalid`.
- Sustained throughput: 1 element/cycle while `oready=1`.
- Stall:
  - `ovalid=1` with `oready=0` holds `out1_s0` and `out1_off_s0` stable;
  - `iready=0` in that case; no RAM write, no counter change.
- Simultaneous drain and accept (`ovalid=1`, `oready=1`, `acc=1`): the new pair replaces the old one and `ovalid` stays 1.
- Reset asserted mid-frame:
  - all state returns to reset values on the next edge;
  - any in-flight output pair is dropped;
  - the next accepted element is treated as idx 0.
- OFFSET=1: FILL lasts exactly one element.
- The frame-wrap element is emitted with RUN data. The element after it starts a fresh FILL.

## Configuration
- `OFFSET_ZERO_FILL_EN`, defined: during FILL, `out1_off_s0 = 0`.
- Undefined (default): during FILL, `out1_off_s0 = first`, the frame's first element, giving edge-clamp semantics. For the idx-0 element this is `in1_s0` itself.
- The `first` register and its load logic are compiled out when the macro is defined.

## Test plan
- Reset then stream 1,2,...,8 (OFFSET=4, oready=1, macro off):
  - `out1_s0` = 1..8;
  - `out1_off_s0` = 1,1,1,1,1,2,3,4;
  - each output one cycle after its accept.
- Same stimulus with `OFFSET_ZERO_FILL_EN`: `out1_off_s0` = 0,0,0,0,1,2,3,4.
- Backpressure: hold `oready=0` for 3 cycles after element 5 is accepted:
  - `ovalid` stays 1 and `iready` stays 0;
  - outputs hold (5,1) with macro off, (5,1) with macro on;
  - stream resumes without loss or duplication.
- Frame wrap with NITEMS=6, OFFSET=2, input 10..21 continuous: the second frame's first two lagged outputs are fill values (16,16 with macro off; 0,0 with macro on), not first-frame data.
- Mid-frame reset after element 3: `ovalid=0` the next cycle, then restart 7,8,9 gives `out1_off_s0` = 7,7,7 with macro off.
- Gapped input (`ivalid` toggling every other cycle): the output sequence is identical to the continuous case, and `ovalid` pulses only after accepts.
